// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath: accumulator sizing, buffer state
// encoding and PE flattening.
package matmul_pkg;

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StPartial = 2'd1,
    StFull    = 2'd2
  } buf_state_e;

  // Product of two DATA_WIDTH operands plus growth for K accumulations.
  function automatic int unsigned acc_width(int unsigned data_width, int unsigned k);
    return 2 * data_width + ((k > 1) ? $clog2(k) : 1);
  endfunction

  function automatic int unsigned flat_idx(int unsigned row, int unsigned col, int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/pe_output_buffer_if.sv
// Controller/PE-array side bundle of the PE output buffer; master is the controller side.
interface pe_output_buffer_if #(
  parameter int unsigned N_PE      = 16,
  parameter int unsigned ACC_WIDTH = 34,
  parameter int unsigned C_WIDTH   = 34,
  parameter int unsigned IDX_WIDTH = 4
);
  logic [N_PE*ACC_WIDTH-1:0] pe_outputs;
  logic [N_PE-1:0]           pe_outputs_valid;
  logic                      capture_en;
  logic                      buffer_reset;
  logic                      read_en;
  logic [IDX_WIDTH-1:0]      read_idx;
  logic [C_WIDTH-1:0]        data_out;
  logic                      data_valid;
  logic                      data_sat;
  logic                      buffer_valid_out;
  logic                      capture_overrun;
  logic                      read_underrun;

  modport master (
    output pe_outputs, pe_outputs_valid, capture_en, buffer_reset, read_en, read_idx,
    input  data_out, data_valid, data_sat, buffer_valid_out, capture_overrun, read_underrun
  );

  modport slave (
    input  pe_outputs, pe_outputs_valid, capture_en, buffer_reset, read_en, read_idx,
    output data_out, data_valid, data_sat, buffer_valid_out, capture_overrun, read_underrun
  );
endinterface

// File: rtl/sat_trunc.sv
// Combinational signed saturator from IN_WIDTH to OUT_WIDTH with an overflow flag.
module sat_trunc #(
  parameter int unsigned IN_WIDTH  = 34,
  parameter int unsigned OUT_WIDTH = 34
) (
  input  logic [IN_WIDTH-1:0]  in_i,
  output logic [OUT_WIDTH-1:0] out_o,
  output logic                 sat_o
);

  if (OUT_WIDTH >= IN_WIDTH) begin : g_pass
    assign out_o = OUT_WIDTH'($signed(in_i));
    assign sat_o = 1'b0;
  end else begin : g_sat
    logic [IN_WIDTH-OUT_WIDTH:0] upper;
    logic                        fits;

    // Value fits when every dropped bit equals the new sign bit.
    assign upper = in_i[IN_WIDTH-1:OUT_WIDTH-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
      sat_o = ~fits;
      out_o = in_i[OUT_WIDTH-1:0];
      if (!fits) begin
        out_o = in_i[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/pe_output_buffer.sv
// Captures the PE accumulator results in parallel and serves them one per cycle by index
// until every entry has been read once.
module pe_output_buffer
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned M          = 4,
  parameter int unsigned N          = 4,
  parameter int unsigned K          = 4,
  parameter int unsigned N_PE       = M * N,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, K),
  parameter int unsigned C_WIDTH    = ACC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_output_buffer_if.slave  bus
);

  typedef logic [N_PE-1:0] mask_t;

  buf_state_e         state_q;
  mask_t              cap_mask_q, rd_mask_q;
  logic [C_WIDTH-1:0] entry_q [N_PE];
  mask_t              entry_sat_q;
  logic [C_WIDTH-1:0] data_out_q;
  logic               data_valid_q, data_sat_q, buf_valid_q, overrun_q, underrun_q;

  logic [C_WIDTH-1:0] sat_val [N_PE];
  mask_t              sat_flag;

  logic  cap_ok, rd_ok;
  mask_t cap_set, cap_next, rd_next;

  for (genvar r = 0; r < M; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int unsigned Idx = flat_idx(r, c, N);
      sat_trunc #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (C_WIDTH)
      ) u_sat (
        .in_i  (bus.pe_outputs[Idx*ACC_WIDTH +: ACC_WIDTH]),
        .out_o (sat_val[Idx]),
        .sat_o (sat_flag[Idx])
      );
    end
  end

  always_comb begin
    cap_ok   = bus.capture_en & ~bus.buffer_reset & (state_q != StFull);
    // Only fill holes; an entry once captured stays put until the buffer drains.
    cap_set  = cap_ok ? (bus.pe_outputs_valid & ~cap_mask_q) : '0;
    cap_next = cap_mask_q | cap_set;
    rd_ok    = bus.read_en & ~bus.buffer_reset & (state_q == StFull)
               & (32'(bus.read_idx) < N_PE);
    rd_next  = rd_mask_q;
    if (rd_ok) begin
      rd_next[bus.read_idx] = 1'b1;
    end
  end

  // Entry storage has no reset: it is only reachable through cap_mask.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_PE); i++) begin
      if (cap_set[i]) begin
        entry_q[i]     <= sat_val[i];
        entry_sat_q[i] <= sat_flag[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      cap_mask_q   <= '0;
      rd_mask_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_sat_q   <= 1'b0;
      buf_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (bus.buffer_reset) begin
        state_q     <= StEmpty;
        cap_mask_q  <= '0;
        rd_mask_q   <= '0;
        buf_valid_q <= 1'b0;
        overrun_q   <= 1'b0;
        underrun_q  <= 1'b0;
      end else begin
        case (state_q)
          StEmpty, StPartial: begin
            if (bus.read_en) begin
              underrun_q <= 1'b1;
            end
            if (|cap_set) begin
              cap_mask_q  <= cap_next;
              state_q     <= (&cap_next) ? StFull : StPartial;
              buf_valid_q <= &cap_next;
            end
          end
          StFull: begin
            if (bus.capture_en) begin
              overrun_q <= 1'b1;
            end
            if (rd_ok) begin
              data_out_q   <= entry_q[bus.read_idx];
              data_sat_q   <= entry_sat_q[bus.read_idx];
              data_valid_q <= 1'b1;
              if (&rd_next) begin
                state_q     <= StEmpty;
                cap_mask_q  <= '0;
                rd_mask_q   <= '0;
                buf_valid_q <= 1'b0;
              end else begin
                rd_mask_q <= rd_next;
              end
            end
          end
          default: begin
            state_q     <= StEmpty;
            cap_mask_q  <= '0;
            rd_mask_q   <= '0;
            buf_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out         = data_out_q;
  assign bus.data_valid       = data_valid_q;
  assign bus.data_sat         = data_sat_q;
  assign bus.buffer_valid_out = buf_valid_q;
  assign bus.capture_overrun  = overrun_q;
  assign bus.read_underrun    = underrun_q;

endmodule

// File: tb/tb_pe_output_buffer.sv
// Directed bench for pe_output_buffer: a full-width instance and a 16-bit saturating one
// share the stimulus and are both compared against a behavioural model every cycle.
module tb_pe_output_buffer;

  localparam int NPE = 16;
  localparam int AW  = 34;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NPE*AW-1:0] pe_in = '0;
  logic [NPE-1:0]    pe_vld = '0;
  logic              cap = 1'b0, brst = 1'b0, ren = 1'b0;
  logic [3:0]        ridx = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_output_buffer_if #(.N_PE(NPE), .ACC_WIDTH(AW), .C_WIDTH(34), .IDX_WIDTH(4)) ifc ();
  pe_output_buffer_if #(.N_PE(NPE), .ACC_WIDTH(AW), .C_WIDTH(16), .IDX_WIDTH(4)) ifs ();

  assign ifc.pe_outputs = pe_in;  assign ifs.pe_outputs = pe_in;
  assign ifc.pe_outputs_valid = pe_vld;  assign ifs.pe_outputs_valid = pe_vld;
  assign ifc.capture_en = cap;    assign ifs.capture_en = cap;
  assign ifc.buffer_reset = brst; assign ifs.buffer_reset = brst;
  assign ifc.read_en = ren;       assign ifs.read_en = ren;
  assign ifc.read_idx = ridx;     assign ifs.read_idx = ridx;

  pe_output_buffer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  pe_output_buffer #(.C_WIDTH(16)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifs)
  );

  // Behavioural model: index 0 is the full-width instance, 1 the 16-bit one.
  int     m_cw [2] = '{34, 16};
  longint m_val [2][NPE];
  bit     m_sat [2][NPE];
  bit     m_cap [2][NPE];
  bit     m_rd  [2][NPE];
  int     m_ncap [2], m_nrd [2];
  bit     m_full [2];
  bit     m_dv [2], m_ds [2], m_ovr [2], m_und [2];
  longint m_do [2];

  function automatic longint sat_to(longint v, int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_clear(int d);
    for (int i = 0; i < NPE; i++) begin
      m_cap[d][i] = 0;
      m_rd[d][i]  = 0;
    end
    m_ncap[d] = 0;
    m_nrd[d]  = 0;
    m_full[d] = 0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      m_dv[d] = 0; m_ds[d] = 0; m_do[d] = 0; m_ovr[d] = 0; m_und[d] = 0;
    end
  endtask

  task automatic model_step();
    longint raw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      m_dv[d] = 0;
      if (brst) begin
        model_clear(d);
        m_ovr[d] = 0;
        m_und[d] = 0;
      end else if (m_full[d]) begin
        if (cap) m_ovr[d] = 1;
        if (ren) begin
          m_do[d] = m_val[d][ridx];
          m_ds[d] = m_sat[d][ridx];
          m_dv[d] = 1;
          if (!m_rd[d][ridx]) begin
            m_rd[d][ridx] = 1;
            m_nrd[d]++;
          end
          if (m_nrd[d] == NPE) model_clear(d);
        end
      end else begin
        if (ren) m_und[d] = 1;
        if (cap) begin
          for (int i = 0; i < NPE; i++) begin
            if (pe_vld[i] && !m_cap[d][i]) begin
              raw = longint'($signed(pe_in[i*AW +: AW]));
              m_val[d][i] = sat_to(raw, m_cw[d]);
              m_sat[d][i] = (m_val[d][i] != raw);
              m_cap[d][i] = 1;
              m_ncap[d]++;
            end
          end
          m_full[d] = (m_ncap[d] == NPE);
        end
      end
    end
  endtask

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(string tag, int d, longint dout, logic dv, logic ds, logic bvo,
                         logic ovr, logic und);
    chk({tag, ".data_valid"}, longint'(dv), longint'(m_dv[d]));
    chk({tag, ".buffer_valid_out"}, longint'(bvo), longint'(m_full[d]));
    chk({tag, ".capture_overrun"}, longint'(ovr), longint'(m_ovr[d]));
    chk({tag, ".read_underrun"}, longint'(und), longint'(m_und[d]));
    if (m_dv[d] || !rst_n) begin
      chk({tag, ".data_out"}, dout, m_do[d]);
      chk({tag, ".data_sat"}, longint'(ds), longint'(m_ds[d]));
    end
  endtask

  always @(negedge clk) begin
    chk_dut("c34", 0, longint'($signed(ifc.data_out)), ifc.data_valid, ifc.data_sat,
            ifc.buffer_valid_out, ifc.capture_overrun, ifc.read_underrun);
    chk_dut("c16", 1, longint'($signed(ifs.data_out)), ifs.data_valid, ifs.data_sat,
            ifs.buffer_valid_out, ifs.capture_overrun, ifs.read_underrun);
  end

  // Present inputs for one edge; returns 1 time unit after that edge with pulses cleared.
  task automatic drive(bit c, bit b, bit r, int idx);
    cap = c; brst = b; ren = r; ridx = 4'(idx);
    @(posedge clk);
    model_step();
    #1;
    cap = 0; brst = 0; ren = 0;
  endtask

  task automatic set_entry(int i, longint v);
    pe_in[i*AW +: AW] = v[AW-1:0];
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("reset.data_out", longint'(ifc.data_out), 0);
    chk("reset.buffer_valid_out", longint'(ifc.buffer_valid_out), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);

    // Full capture and back-to-back drain.
    for (int i = 0; i < NPE; i++) set_entry(i, i * 100);
    pe_vld = 16'hFFFF;
    drive(1, 0, 0, 0);
    chk("full.bvo_after_capture", longint'(ifc.buffer_valid_out), 1);
    for (int i = 0; i < NPE; i++) begin
      drive(0, 0, 1, i);
      chk("drain.data_out", longint'(ifc.data_out), i * 100);
      chk("drain.bvo", longint'(ifc.buffer_valid_out), (i < NPE - 1) ? 1 : 0);
    end
    drive(0, 0, 0, 0);
    chk("drain.dv_after_last", longint'(ifc.data_valid), 0);

    // Partial capture, underrun, then fill the remainder with new data.
    for (int i = 0; i < NPE; i++) set_entry(i, i * 100 + 7);
    pe_vld = 16'h00FF;
    drive(1, 0, 0, 0);
    chk("partial.bvo", longint'(ifc.buffer_valid_out), 0);
    drive(0, 0, 1, 3);
    chk("underrun.dv", longint'(ifc.data_valid), 0);
    chk("underrun.flag", longint'(ifc.read_underrun), 1);
    for (int i = 0; i < NPE; i++) set_entry(i, i * 1000 + 1);
    pe_vld = 16'hFFFF;
    drive(1, 0, 0, 0);
    chk("partial.bvo_full", longint'(ifc.buffer_valid_out), 1);
    drive(0, 0, 1, 0);
    chk("partial.keep_e0", longint'(ifc.data_out), 7);
    drive(0, 0, 1, 8);
    chk("partial.new_e8", longint'(ifc.data_out), 8001);
    drive(0, 0, 1, 15);
    chk("partial.new_e15", longint'(ifc.data_out), 15001);
    drive(1, 0, 1, 3);
    chk("overrun.data_e3", longint'(ifc.data_out), 307);
    chk("overrun.dv", longint'(ifc.data_valid), 1);
    chk("overrun.flag", longint'(ifc.capture_overrun), 1);
    drive(0, 1, 0, 0);
    chk("brst.overrun_clr", longint'(ifc.capture_overrun), 0);
    chk("brst.underrun_clr", longint'(ifc.read_underrun), 0);
    chk("brst.bvo", longint'(ifc.buffer_valid_out), 0);

    // Saturation on the 16-bit instance; pass-through on the full-width one.
    for (int i = 0; i < NPE; i++) set_entry(i, i);
    set_entry(0, 64'sh1_0000);
    set_entry(1, -70000);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("sat.pos_c16", longint'($signed(ifs.data_out)), 32767);
    chk("sat.pos_flag", longint'(ifs.data_sat), 1);
    chk("sat.pos_c34", longint'($signed(ifc.data_out)), 65536);
    drive(0, 0, 1, 1);
    chk("sat.neg_c16", longint'($signed(ifs.data_out)), -32768);
    chk("sat.neg_flag", longint'(ifs.data_sat), 1);
    chk("sat.neg_c34", longint'($signed(ifc.data_out)), -70000);
    for (int i = 2; i < 7; i++) begin
      drive(0, 0, 1, i);
      if (i == 5) begin
        chk("sat.e5_c16", longint'($signed(ifs.data_out)), 5);
        chk("sat.e5_flag", longint'(ifs.data_sat), 0);
      end
    end

    // Buffer reset after 7 reads, with a read dropped in the same cycle.
    drive(0, 1, 1, 7);
    chk("midreset.dv", longint'(ifc.data_valid), 0);
    chk("midreset.bvo", longint'(ifc.buffer_valid_out), 0);
    drive(1, 0, 0, 0);
    chk("midreset.recapture", longint'(ifc.buffer_valid_out), 1);

    // Duplicate reads: only the read covering index 15 completes the drain.
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 1, 2);
      chk("dup.e2", longint'($signed(ifc.data_out)), 2);
    end
    for (int i = 0; i < NPE; i++) begin
      drive(0, 0, 1, i);
      chk("dup.bvo", longint'(ifc.buffer_valid_out), (i == NPE - 1) ? 0 : 1);
    end
    chk("dup.last_dv", longint'(ifc.data_valid), 1);

    // Asynchronous reset mid-drain.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, i + 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.data_out", longint'(ifc.data_out), 0);
    chk("arst.dv", longint'(ifc.data_valid), 0);
    chk("arst.bvo", longint'(ifc.buffer_valid_out), 0);
    chk("arst.c16_data_out", longint'(ifs.data_out), 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 1, 0);
    chk("arst.empty_underrun", longint'(ifc.read_underrun), 1);
    drive(1, 0, 0, 0);
    chk("arst.recapture", longint'(ifc.buffer_valid_out), 1);
    drive(0, 0, 1, 9);
    chk("arst.read_e9", longint'(ifc.data_out), 9);
    drive(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_output_buffer.md
# pe_output_buffer

Holding buffer between the PE array and the C BRAM write port of the matrix-multiply datapath. It captures the M×N PE accumulator results in parallel when the controller pulses `capture_en`, then serves them one element per cycle by index for the controller's C BRAM write sequence. It reports "all results held" to the controller through `buffer_valid_out`, and releases itself once every element has been read.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of the A/B elements.
- `M`, 4: number of PE rows.
- `N`, 4: number of PE columns.
- `K`, 4: accumulation depth.
- `N_PE`, M*N: number of buffer entries.
- `ACC_WIDTH`, 2*DATA_WIDTH + $clog2(K) (K>1, else +1): PE accumulator width, signed.
- `C_WIDTH`, ACC_WIDTH: stored width of a C element. Must satisfy C_WIDTH ≤ ACC_WIDTH.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `pe_outputs`, in, N_PE*ACC_WIDTH: flattened PE results; entry i is at [i*ACC_WIDTH +: ACC_WIDTH], with i = row*N + col.
- `pe_outputs_valid`, in, N_PE: per-PE result-valid flags.
- `capture_en`, in, 1: capture request from the controller.
- `buffer_reset`, in, 1: synchronous clear from the controller.
- `read_en`, in, 1: read request.
- `read_idx`, in, $clog2(N_PE): entry to read; driven from the controller's `pe_write_idx_in`.
- `data_out`, out, C_WIDTH: registered read data.
- `data_valid`, out, 1: `data_out` holds a served read this cycle.
- `data_sat`, out, 1: the served read was saturated.
- `buffer_valid_out`, out, 1: all N_PE entries captured and not yet fully drained.
- `capture_overrun`, out, 1: sticky; a capture was attempted while FULL.
- `read_underrun`, out, 1: sticky; a read was attempted while not FULL.

## Operation
- **State machine.** States are EMPTY, PARTIAL and FULL. The block keeps two N_PE-bit masks: `cap_mask` and `rd_mask`.
- **Capture in EMPTY or PARTIAL.** On `capture_en`, every entry i with `pe_outputs_valid[i]`=1 and `cap_mask[i]`=0 is stored and its `cap_mask` bit is set. Entries already captured are never overwritten.
  - After the update, if `cap_mask` is all-ones, go to FULL.
  - Otherwise, if any bit is set, go to or stay in PARTIAL.
  - `capture_en` with no valid bits leaves the state unchanged.
- **Saturation on capture.** Each stored value is signed-saturated from ACC_WIDTH to C_WIDTH: clamp to 2^(C_WIDTH-1)-1 or -2^(C_WIDTH-1). A per-entry sat bit is stored with the value. When C_WIDTH = ACC_WIDTH, the value passes through unchanged and sat = 0.
- **Read in FULL.** `read_en` with `read_idx` < N_PE registers entry[read_idx] to `data_out` and its sat bit to `data_sat`, sets `data_valid`, and sets `rd_mask[read_idx]`.
  - Re-reading an index is allowed; it is counted once.
  - `read_idx` ≥ N_PE gives `data_valid`=0 and no mask change.
- **Drain.** When `rd_mask` becomes all-ones, the next state is EMPTY and both masks clear. The final read's data is still presented normally.
- **Read outside FULL.** `read_en` in EMPTY or PARTIAL gives `data_valid`=0 and sets `read_underrun`.
- **Capture in FULL.** `capture_en` in FULL is ignored and sets `capture_overrun`.
- **Capture and read together in FULL.** The read is served and `capture_overrun` is set.
- **Buffer reset.** `buffer_reset` has the highest priority in every state. It goes to EMPTY, clears both masks and both sticky flags, and forces `data_valid`=0 on the next cycle. A capture or read in the same cycle is dropped.
- **Data after reset.** Entry contents are not cleared by `buffer_reset`, but they are unreachable until recaptured.

## Timing
- **Reset values.** While `rst_n`=0: state EMPTY; masks 0; `data_out`=0; `data_valid`=0; `data_sat`=0; `buffer_valid_out`=0; `capture_overrun`=0; `read_underrun`=0.
- **Capture to FULL.** A `capture_en` at edge t that completes `cap_mask` makes `buffer_valid_out`=1 after edge t. It is registered and equals (state==FULL).
- **Read latency: 1 cycle.** A `read_en` sampled at edge t puts `data_out`, `data_valid` and `data_sat` valid after edge t, for one cycle. The controller delays `we_c_bram_in`/`addr_c_bram_in` by one cycle to match.
- **Drain.** The read completing `rd_mask` at edge t drops `buffer_valid_out` after edge t, in the same cycle that `data_valid` presents the last element.
- **Back-to-back.** One read per cycle is sustained, with no bubbles.
- **Asynchronous reset mid-drain.** All outputs go to their reset values immediately. After release, the block is in EMPTY.

## Structure
- **Shared package `matmul_pkg`:**
  - ACC_WIDTH derivation function (shared with the PE and controller).
  - State encoding (EMPTY=2'd0, PARTIAL=2'd1, FULL=2'd2).
  - Flattened-index helper row*N+col.
- **Sub-module `sat_trunc`:** combinational signed saturator, ACC_WIDTH→C_WIDTH, with a sat flag. It is instantiated per entry on the capture path.

## Test plan
Defaults M=N=K=4, DATA_WIDTH=16: N_PE=16, ACC_WIDTH=34.
- **Full capture and drain.** Capture all 16 valid with entry i = i*100; read idx 0..15 back-to-back.
  - Required: `data_out`=0,100,…,1500, each one cycle after its `read_en`.
  - Required: `buffer_valid_out` falls with the last `data_valid`; state returns to EMPTY.
- **Partial capture.**
  - Capture with valid=16'h00FF: state PARTIAL, `buffer_valid_out`=0.
  - Capture again with valid=16'hFFFF and new data: entries 0–7 keep their first values, entries 8–15 take the new ones, state FULL.
- **Overrun and underrun.**
  - `read_en` while PARTIAL: `data_valid`=0, `read_underrun`=1.
  - `capture_en` together with a read of idx 3 while FULL: entry 3 is returned, `capture_overrun`=1.
  - `buffer_reset` then clears both flags.
- **Saturation, C_WIDTH=16.** Entries 34'sh0_0001_0000 and -70000 read as 32767 and -32768 with `data_sat`=1; entry 5 reads 5 with `data_sat`=0.
- **Reset mid-drain.**
  - `buffer_reset` after 7 reads: the next cycle has `data_valid`=0, state EMPTY; a new capture is accepted.
  - `rst_n` low mid-drain: all outputs go to 0 asynchronously.
- **Duplicate reads.** Read idx 2 three times, then 0..15: drain completes only on the read that covers the final unread index.
